// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, signed or unsigned per transaction,
// retiring BITS_PER_CYCLE quotient bits per clock behind valid/ready handshakes.
module seq_divider #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             dbz_out,
  output logic             ovf_out
);

  localparam int unsigned ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH-1:0] div_abs;
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] iter_cnt;

  logic             dvd_neg_c;
  logic             dvs_neg_c;
  logic [WIDTH-1:0] dvd_abs_c;
  logic [WIDTH-1:0] dvs_abs_c;
  logic [WIDTH-1:0] step_rem_c;
  logic [WIDTH-1:0] step_quo_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] q_fix_c;
  logic [WIDTH-1:0] r_fix_c;

  // Operand magnitudes; unsigned mode passes raw values through
  always_comb begin
    dvd_neg_c = signed_in & dividend_in[WIDTH-1];
    dvs_neg_c = signed_in & divisor_in[WIDTH-1];
    dvd_abs_c = dvd_neg_c ? WIDTH'(WIDTH'(0) - dividend_in) : dividend_in;
    dvs_abs_c = dvs_neg_c ? WIDTH'(WIDTH'(0) - divisor_in) : divisor_in;
  end

  // Chained restoring steps; quo_sh feeds dividend bits from its MSB and collects quotient bits at its LSB
  always_comb begin
    step_rem_c = part_rem;
    step_quo_c = quo_sh;
    shifted_c  = '0;
    trial_c    = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      shifted_c  = {step_rem_c, step_quo_c[WIDTH-1]};
      step_quo_c = {step_quo_c[WIDTH-2:0], 1'b0};
      trial_c    = shifted_c - {1'b0, div_abs};
      if (!trial_c[WIDTH]) begin
        step_rem_c    = trial_c[WIDTH-1:0];
        step_quo_c[0] = 1'b1;
      end else begin
        step_rem_c = shifted_c[WIDTH-1:0];
      end
    end
    q_fix_c = neg_q ? WIDTH'(WIDTH'(0) - step_quo_c) : step_quo_c;
    r_fix_c = neg_r ? WIDTH'(WIDTH'(0) - step_rem_c) : step_rem_c;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      ready_out     <= 1'b0;
      valid_out     <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
      dbz_out       <= 1'b0;
      ovf_out       <= 1'b0;
      part_rem      <= '0;
      quo_sh        <= '0;
      div_abs       <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      iter_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && ready_out) begin
            ready_out <= 1'b0;
            iter_cnt  <= '0;
            part_rem  <= '0;
            quo_sh    <= dvd_abs_c;
            div_abs   <= dvs_abs_c;
            neg_q     <= dvd_neg_c ^ dvs_neg_c;
            neg_r     <= dvd_neg_c;
            if (divisor_in == '0) begin
              state         <= DONE;
              valid_out     <= 1'b1;
              quotient_out  <= '1;
              remainder_out <= dividend_in;
              dbz_out       <= 1'b1;
            end else if (signed_in && dividend_in == MIN_VAL && divisor_in == '1) begin
              state         <= DONE;
              valid_out     <= 1'b1;
              quotient_out  <= MIN_VAL;
              remainder_out <= '0;
              ovf_out       <= 1'b1;
            end else begin
              state <= CALC;
            end
          end else begin
            ready_out <= 1'b1;
          end
        end
        CALC: begin
          part_rem <= step_rem_c;
          quo_sh   <= step_quo_c;
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (iter_cnt == LAST_CNT) begin
            state         <= DONE;
            valid_out     <= 1'b1;
            quotient_out  <= q_fix_c;
            remainder_out <= r_fix_c;
          end
        end
        DONE: begin
          // Results stay frozen until the consumer takes them
          if (ready_in) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            dbz_out   <= 1'b0;
            ovf_out   <= 1'b0;
            ready_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: 8-bit/1-bit-per-cycle and 16-bit/4-bit-per-cycle instances
// checked every valid cycle against an arithmetic reference model.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_vin, a_rdy, a_sgn, a_vout, a_rin, a_dbz, a_ovf;
  logic [7:0] a_dd, a_dv, a_q, a_r;
  logic        b_vin, b_rdy, b_sgn, b_vout, b_rin, b_dbz, b_ovf;
  logic [15:0] b_dd, b_dv, b_q, b_r;

  seq_divider #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_a (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(a_vin), .ready_out(a_rdy), .signed_in(a_sgn),
    .dividend_in(a_dd), .divisor_in(a_dv), .valid_out(a_vout), .ready_in(a_rin),
    .quotient_out(a_q), .remainder_out(a_r), .dbz_out(a_dbz), .ovf_out(a_ovf));

  seq_divider #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(b_vin), .ready_out(b_rdy), .signed_in(b_sgn),
    .dividend_in(b_dd), .divisor_in(b_dv), .valid_out(b_vout), .ready_in(b_rin),
    .quotient_out(b_q), .remainder_out(b_r), .dbz_out(b_dbz), .ovf_out(b_ovf));

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  bit   a_seen, b_seen;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_a = 0;
  int   done_b = 0;
  logic [7:0]  last_aq, last_ar;
  logic        last_adbz, last_aovf;
  logic [15:0] last_bq, last_br;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with truncation toward zero, plus the two shortcut cases
  function automatic exp_t model(input int w, input int iter, input logic sgn,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    longint sa, sb;
    longint mask;
    mask  = (longint'(1) << w) - 1;
    e.q   = '0;
    e.r   = '0;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.acc = 0;
    if (b == 16'd0) begin
      e.q   = 16'(mask);
      e.r   = a;
      e.dbz = 1'b1;
    end else if (sgn) begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      if (sa == -(longint'(1) << (w-1)) && sb == -1) begin
        e.q   = 16'(longint'(1) << (w-1));
        e.ovf = 1'b1;
      end else begin
        e.q = 16'((sa / sb) & mask);
        e.r = 16'((sa % sb) & mask);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.lat = (e.dbz || e.ovf) ? 1 : iter + 1;
    return e;
  endfunction

  // Single compare process: outputs checked on every cycle they are meaningful
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      a_seen = 1'b0;
      b_seen = 1'b0;
    end else begin
      if (a_vout) begin
        if (qa.size() == 0) chk("a_spurious_valid", 32'(a_vout), 32'd0);
        else begin
          if (!a_seen) begin chk("a_latency", 32'(cyc - qa[0].acc), 32'(qa[0].lat)); a_seen = 1'b1; end
          chk("a_quotient",  32'(a_q),   32'(qa[0].q[7:0]));
          chk("a_remainder", 32'(a_r),   32'(qa[0].r[7:0]));
          chk("a_dbz",       32'(a_dbz), 32'(qa[0].dbz));
          chk("a_ovf",       32'(a_ovf), 32'(qa[0].ovf));
          chk("a_ready_in_done", 32'(a_rdy), 32'd0);
          if (a_rin) begin
            last_aq = a_q; last_ar = a_r; last_adbz = a_dbz; last_aovf = a_ovf;
            void'(qa.pop_front());
            a_seen = 1'b0;
            done_a++;
          end
        end
      end else begin
        chk("a_flags_idle", {30'd0, a_dbz, a_ovf}, 32'd0);
      end
      if (a_vin && a_rdy) begin
        e = model(8, 8, a_sgn, 16'(a_dd), 16'(a_dv));
        e.acc = cyc;
        qa.push_back(e);
      end

      if (b_vout) begin
        if (qb.size() == 0) chk("b_spurious_valid", 32'(b_vout), 32'd0);
        else begin
          if (!b_seen) begin chk("b_latency", 32'(cyc - qb[0].acc), 32'(qb[0].lat)); b_seen = 1'b1; end
          chk("b_quotient",  32'(b_q),   32'(qb[0].q));
          chk("b_remainder", 32'(b_r),   32'(qb[0].r));
          chk("b_dbz",       32'(b_dbz), 32'(qb[0].dbz));
          chk("b_ovf",       32'(b_ovf), 32'(qb[0].ovf));
          if (b_rin) begin
            last_bq = b_q; last_br = b_r;
            void'(qb.pop_front());
            b_seen = 1'b0;
            done_b++;
          end
        end
      end
      if (b_vin && b_rdy) begin
        e = model(16, 4, b_sgn, b_dd, b_dv);
        e.acc = cyc;
        qb.push_back(e);
      end
    end
  end

  task automatic issue_a(input logic sgn, input logic [7:0] dd, input logic [7:0] dv);
    int t = 0;
    while (!a_rdy && t < 60) begin @(posedge clk); #1; t++; end
    if (!a_rdy) chk("a_ready_timeout", 32'd0, 32'd1);
    a_sgn = sgn; a_dd = dd; a_dv = dv; a_vin = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the result must not depend on them
    a_vin = 1'b0; a_sgn = 1'($urandom); a_dd = 8'($urandom); a_dv = 8'($urandom);
  endtask

  task automatic wait_a(input int d0);
    int t = 0;
    while (done_a == d0 && t < 60) begin @(posedge clk); #1; t++; end
    if (done_a == d0) chk("a_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic op_a(input logic sgn, input logic [7:0] dd, input logic [7:0] dv);
    int d0 = done_a;
    issue_a(sgn, dd, dv);
    wait_a(d0);
  endtask

  task automatic op_b(input logic sgn, input logic [15:0] dd, input logic [15:0] dv);
    int t = 0;
    int d0 = done_b;
    while (!b_rdy && t < 60) begin @(posedge clk); #1; t++; end
    if (!b_rdy) chk("b_ready_timeout", 32'd0, 32'd1);
    b_sgn = sgn; b_dd = dd; b_dv = dv; b_vin = 1'b1;
    @(posedge clk); #1;
    b_vin = 1'b0; b_dd = 16'($urandom); b_dv = 16'($urandom);
    t = 0;
    while (done_b == d0 && t < 60) begin @(posedge clk); #1; t++; end
    if (done_b == d0) chk("b_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_a_zero(input string tag);
    chk(tag, {a_rdy, a_vout, a_dbz, a_ovf, 8'd0, a_q, a_r, 4'd0}, 32'd0);
  endtask

  task automatic chk_a_lit(input string tag, input logic [7:0] q, input logic [7:0] r,
                           input logic dbz, input logic ovf);
    chk(tag, {14'd0, last_adbz, last_aovf, last_aq, last_ar}, {14'd0, dbz, ovf, q, r});
  endtask

  initial begin
    int d0;
    int t;
    logic [15:0] dd, dv;
    rst_n = 1'b0;
    a_vin = 1'b0; a_sgn = 1'b0; a_dd = '0; a_dv = '0; a_rin = 1'b1;
    b_vin = 1'b0; b_sgn = 1'b0; b_dd = '0; b_dv = '0; b_rin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_a_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(a_rdy), 32'd1);

    op_a(1'b0, 8'd100, 8'd7);  chk_a_lit("u_100_7",   8'd14,  8'd2,  1'b0, 1'b0);
    op_a(1'b1, 8'hF9, 8'h02);  chk_a_lit("s_m7_2",    8'hFD,  8'hFF, 1'b0, 1'b0);
    op_a(1'b1, 8'h07, 8'hFE);  chk_a_lit("s_7_m2",    8'hFD,  8'h01, 1'b0, 1'b0);
    op_a(1'b0, 8'd45, 8'd0);   chk_a_lit("u_45_0",    8'hFF,  8'd45, 1'b1, 1'b0);
    op_a(1'b1, 8'h80, 8'hFF);  chk_a_lit("s_min_m1",  8'h80,  8'h00, 1'b0, 1'b1);
    op_a(1'b0, 8'h80, 8'hFF);  chk_a_lit("u_80_ff",   8'h00,  8'h80, 1'b0, 1'b0);
    op_a(1'b1, 8'h9C, 8'h07);  chk_a_lit("s_m100_7",  8'hF2,  8'hFE, 1'b0, 1'b0);
    op_a(1'b0, 8'd255, 8'd1);  chk_a_lit("u_255_1",   8'hFF,  8'h00, 1'b0, 1'b0);

    // Backpressure: result held while valid_in and operands churn
    a_rin = 1'b0;
    d0 = done_a;
    issue_a(1'b0, 8'd100, 8'd7);
    t = 0;
    while (!a_vout && t < 60) begin @(posedge clk); #1; t++; end
    chk("bp_valid_reached", 32'(a_vout), 32'd1);
    repeat (5) begin
      a_vin = ~a_vin; a_sgn = 1'($urandom); a_dd = 8'($urandom); a_dv = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("bp_no_accept", 32'(qa.size()), 32'd1);
    a_vin = 1'b0;
    a_rin = 1'b1;
    wait_a(d0);
    chk_a_lit("bp_result", 8'd14, 8'd2, 1'b0, 1'b0);
    op_a(1'b0, 8'd50, 8'd6);   chk_a_lit("after_bp",  8'd8,   8'd2,  1'b0, 1'b0);

    // Reset during CALC discards the in-flight operation
    issue_a(1'b0, 8'd100, 8'd7);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_a_zero("reset_mid_calc");
    @(posedge clk); #1;
    rst_n = 1'b1;
    op_a(1'b0, 8'd200, 8'd9);  chk_a_lit("u_200_9",   8'd22,  8'd2,  1'b0, 1'b0);

    // Wide instance: pinned case, then a mixed sweep against the model
    op_b(1'b1, 16'hFC18, 16'd7);
    chk("b_s_m1000_7", {last_bq, last_br}, {16'hFF72, 16'hFFFA});
    for (int i = 0; i < 40; i++) begin
      dd = 16'($urandom);
      dv = (i % 3 == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom);
      if (i % 7 == 0)  dv = 16'd0;
      if (i % 9 == 0)  begin dd = 16'h8000; dv = 16'hFFFF; end
      if (i % 13 == 5) dv = 16'hFFFF;
      op_b(1'(i), dd, dv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
